seq_ctrl_fsm: RTL and testbench
===============================

SEQ_CTRL_FSM -- requirements
Module: seq_ctrl_fsm

Interface
REQ-001 Parameters (name, default, meaning), one per line; every *_LEN shall lie in 1..15; CHECK_LEN shall be even; LOOP_MID shall be less than LOOP_LEN-1:
- INIT_LEN, 4, init steps.
- CHECK_LEN, 8, check steps.
- EXCH_LEN, 3, exchange steps.
- PRE_LEN, 2, pre-loop steps.
- LOOP_LEN, 11, loop-body steps.
- LOOP_MID, 5, mid-loop test step (0-based).
- END_LEN, 2, end steps.
- ITER_W, 8, iteration counter width.
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
- clk, in, 1, single clock; rising edge.
- reset, in, 1, asynchronous, active-low reset.
- load, in, 1, start request; sampled in IDLE only.
- flag_z1, in, 1, datapath zero flag.
- flag_s1, in, 1, datapath sign/swap flag.
- scan_en, in, 1, test state-injection enable.
- scan_phase, in, 3, injected phase.
- scan_step, in, 4, injected step.
- phase, out, 3, current phase.
- step, out, 4, step within phase.
- busy, out, 1, phase is neither IDLE nor ERR.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, sticky iteration-overflow flag.
- iter, out, ITER_W, completed loop iterations.

Function
REQ-003 Phase encoding shall be: IDLE=0, INIT=1, CHECK=2, EXCH=3, PRE=4, LOOP=5, END=6, ERR=7. The state is {phase, step}; all outputs shall be registered.
REQ-004 Within any phase except IDLE and ERR, step shall increment by 1 per cycle unless a rule below redirects it; on leaving a phase, the step of the next phase shall be 0.
REQ-005 IDLE: load=1 -> INIT/0; iter cleared to 0; err cleared to 0. load in any other phase shall be ignored.
REQ-006 INIT, last step: flag_s1=1 -> IDLE (abort, no done pulse); flag_s1=0 -> CHECK/0.
REQ-007 CHECK, any odd step with flag_z1=1 -> END/0; this rule shall take precedence over the last-step rule.
REQ-008 CHECK, last step with flag_z1=0: flag_s1=1 -> EXCH/0; flag_s1=0 -> PRE/0.
REQ-009 EXCH, last step -> PRE/0.
REQ-010 PRE, last step -> LOOP/0.
REQ-011 LOOP, step LOOP_MID: flag_z1=0 -> LOOP/0 with iter+1; flag_z1=1 -> step+1.
REQ-012 LOOP, last step: flag_z1=1 -> END/0; flag_z1=0 -> LOOP/0 with iter+1.
REQ-013 Iteration overflow: an increment attempted while iter is all-ones shall instead go to ERR/0, hold iter, and set err=1. iter shall never wrap.
REQ-014 ERR shall go to IDLE/0 on the next cycle; err shall stay at 1 until the next accepted load.
REQ-015 END, last step -> IDLE/0, with done=1 for exactly the following cycle; done shall be 0 at all other times.
REQ-016 Any illegal state (step >= the length of its phase, or IDLE/ERR with step != 0) shall go to IDLE/0 on the next cycle, with no done pulse and err unchanged.

Reset
REQ-017 reset=0 shall asynchronously force: phase=IDLE, step=0, iter=0, busy=0, done=0, err=0. Operation shall resume on the first rising clk edge after reset is released.
REQ-018 Reset asserted mid-operation shall abandon the sequence with no done pulse.

Configuration
REQ-019 Macro SEQ_CTRL_SCAN_EN: when defined, scan_en=1 shall load {phase, step} from {scan_phase, scan_step} on the next edge, with priority over all other rules; iter and err are unaffected, and an illegal injected state is handled by REQ-016. When undefined, scan_en, scan_phase and scan_step remain as ports but shall be ignored.

Verification
REQ-020 Release reset, hold load=1 for one cycle with both flags 0 -> INIT/0..3, CHECK/0..7, PRE/0..1, LOOP/0.
REQ-021 From the previous scenario, set flag_s1=1 before CHECK/7 -> EXCH/0..2 then PRE/0; set flag_z1=1 from LOOP/5 -> reaches LOOP/10, then END/0..1, IDLE with done=1 for one cycle, iter=0.
REQ-022 With ITER_W=2 and flag_z1=0 in LOOP -> iter=1, 2, 3, then ERR/0 with err=1, IDLE next cycle, iter holds 3; a new load clears err.
REQ-023 With SEQ_CTRL_SCAN_EN defined, inject CHECK/3 with flag_z1=1 -> END/0; inject INIT/3 with flag_s1=1 -> IDLE with done=0; inject IDLE/9 -> IDLE/0.
REQ-024 Assert reset=0 mid-cycle while in LOOP/4 -> outputs reach reset values immediately, without a clk edge; done stays 0. Without the macro, scan_en=1 has no effect on the state.

Source files
------------

// File: rtl/seq_ctrl_fsm.sv
// Phase/step sequencer: init, check, exchange, pre-loop, loop, end.
// Optional state injection for test under macro SEQ_CTRL_SCAN_EN.
module seq_ctrl_fsm #(
  parameter int INIT_LEN  = 4,
  parameter int CHECK_LEN = 8,
  parameter int EXCH_LEN  = 3,
  parameter int PRE_LEN   = 2,
  parameter int LOOP_LEN  = 11,
  parameter int LOOP_MID  = 5,
  parameter int END_LEN   = 2,
  parameter int ITER_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flag_z1,
  input  logic              flag_s1,
  input  logic              scan_en,
  input  logic [2:0]        scan_phase,
  input  logic [3:0]        scan_step,
  output logic [2:0]        phase,
  output logic [3:0]        step,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter
);

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_INIT  = 3'd1,
    P_CHECK = 3'd2,
    P_EXCH  = 3'd3,
    P_PRE   = 3'd4,
    P_LOOP  = 3'd5,
    P_END   = 3'd6,
    P_ERR   = 3'd7
  } phase_e;

  phase_e            ph_q, ph_d;
  logic [3:0]        st_q, st_d;
  logic [ITER_W-1:0] it_q, it_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [3:0]        len;
  logic              last;
  logic              illegal;
  logic              inc;

  // IDLE and ERR are single-step phases
  always_comb begin
    len = 4'd1;
    case (ph_q)
      P_INIT:  len = 4'(INIT_LEN);
      P_CHECK: len = 4'(CHECK_LEN);
      P_EXCH:  len = 4'(EXCH_LEN);
      P_PRE:   len = 4'(PRE_LEN);
      P_LOOP:  len = 4'(LOOP_LEN);
      P_END:   len = 4'(END_LEN);
      default: len = 4'd1;
    endcase
  end

  assign last    = (st_q == len - 4'd1);
  assign illegal = (st_q >= len);

  always_comb begin
    ph_d   = ph_q;
    st_d   = st_q + 4'd1;
    it_d   = it_q;
    err_d  = err_q;
    done_d = 1'b0;
    inc    = 1'b0;
    if (illegal) begin
      ph_d = P_IDLE;
      st_d = 4'd0;
    end else begin
      unique case (ph_q)
        P_IDLE: begin
          st_d = 4'd0;
          if (load) begin
            ph_d  = P_INIT;
            it_d  = '0;
            err_d = 1'b0;
          end
        end
        P_INIT: begin
          if (last) begin
            ph_d = flag_s1 ? P_IDLE : P_CHECK;
            st_d = 4'd0;
          end
        end
        P_CHECK: begin
          if (st_q[0] && flag_z1) begin
            ph_d = P_END;
            st_d = 4'd0;
          end else if (last) begin
            ph_d = flag_s1 ? P_EXCH : P_PRE;
            st_d = 4'd0;
          end
        end
        P_EXCH: begin
          if (last) begin
            ph_d = P_PRE;
            st_d = 4'd0;
          end
        end
        P_PRE: begin
          if (last) begin
            ph_d = P_LOOP;
            st_d = 4'd0;
          end
        end
        P_LOOP: begin
          if (st_q == 4'(LOOP_MID)) begin
            inc = !flag_z1;
          end else if (last) begin
            if (flag_z1) begin
              ph_d = P_END;
              st_d = 4'd0;
            end else begin
              inc = 1'b1;
            end
          end
        end
        P_END: begin
          if (last) begin
            ph_d   = P_IDLE;
            st_d   = 4'd0;
            done_d = 1'b1;
          end
        end
        P_ERR: begin
          ph_d = P_IDLE;
          st_d = 4'd0;
        end
      endcase
    end

    // iter saturates: overflow diverts to ERR instead of wrapping
    if (inc) begin
      st_d = 4'd0;
      if (&it_q) begin
        ph_d  = P_ERR;
        err_d = 1'b1;
      end else begin
        ph_d = P_LOOP;
        it_d = it_q + ITER_W'(1);
      end
    end

`ifdef SEQ_CTRL_SCAN_EN
    if (scan_en) begin
      ph_d   = phase_e'(scan_phase);
      st_d   = scan_step;
      it_d   = it_q;
      err_d  = err_q;
      done_d = 1'b0;
    end
`endif

    busy_d = (ph_d != P_IDLE) && (ph_d != P_ERR);
  end

`ifndef SEQ_CTRL_SCAN_EN
  logic unused_scan;
  assign unused_scan = ^{scan_en, scan_phase, scan_step};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q   <= P_IDLE;
      st_q   <= 4'd0;
      it_q   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      st_q   <= st_d;
      it_q   <= it_d;
      err_q  <= err_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign phase = ph_q;
  assign step  = st_q;
  assign iter  = it_q;
  assign err   = err_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Bench for seq_ctrl_fsm: directed scenarios plus random stimulus
// against a phase-length table model (ITER_W=2 to reach overflow).
module tb_seq_ctrl_fsm;

  localparam int IW  = 2;
  localparam int MID = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic          flag_z1 = 1'b0;
  logic          flag_s1 = 1'b0;
  logic          scan_en = 1'b0;
  logic [2:0]    scan_phase = 3'd0;
  logic [3:0]    scan_step = 4'd0;
  logic [2:0]    phase;
  logic [3:0]    step;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW-1:0] iter;

  int errors = 0;
  int checks = 0;
  int m_ph, m_st, m_it, m_err, m_done;

  seq_ctrl_fsm #(.ITER_W(IW)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .flag_z1(flag_z1),
    .flag_s1(flag_s1),
    .scan_en(scan_en),
    .scan_phase(scan_phase),
    .scan_step(scan_step),
    .phase(phase),
    .step(step),
    .busy(busy),
    .done(done),
    .err(err),
    .iter(iter)
  );

  always #5 clk = ~clk;

  function automatic int plen(int p);
    case (p)
      1: return 4;
      2: return 8;
      3: return 3;
      4: return 2;
      5: return 11;
      6: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_st = 0; m_it = 0; m_err = 0; m_done = 0;
  endtask

  task automatic goto(int p);
    m_ph = p;
    m_st = 0;
  endtask

  task automatic model_step();
    bit last;
    bit inc;
    inc = 0;
    m_done = 0;
    if (!reset) begin
      model_reset();
      return;
    end
`ifdef SEQ_CTRL_SCAN_EN
    if (scan_en) begin
      m_ph = int'(scan_phase);
      m_st = int'(scan_step);
      return;
    end
`endif
    if (m_st >= plen(m_ph)) begin
      goto(0);
      return;
    end
    last = (m_st == plen(m_ph) - 1);
    case (m_ph)
      0: if (load) begin goto(1); m_it = 0; m_err = 0; end
      1: if (last) goto(flag_s1 ? 0 : 2); else m_st++;
      2: begin
        if ((m_st % 2) == 1 && flag_z1) goto(6);
        else if (last) goto(flag_s1 ? 3 : 4);
        else m_st++;
      end
      3: if (last) goto(4); else m_st++;
      4: if (last) goto(5); else m_st++;
      5: begin
        if (m_st == MID) begin
          if (flag_z1) m_st++; else inc = 1;
        end else if (last) begin
          if (flag_z1) goto(6); else inc = 1;
        end else m_st++;
      end
      6: if (last) begin goto(0); m_done = 1; end else m_st++;
      default: goto(0);
    endcase
    if (inc) begin
      if (m_it == (1 << IW) - 1) begin
        goto(7);
        m_err = 1;
      end else begin
        goto(5);
        m_it++;
      end
    end
  endtask

  task automatic compare_all();
    check("phase", phase, m_ph);
    check("step", step, m_st);
    check("iter", iter, m_it);
    check("err", err, m_err);
    check("done", done, m_done);
    check("busy", busy, (m_ph != 0 && m_ph != 7));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_to_idle();
    flag_s1 = 0;
    flag_z1 = 1;
    for (int i = 0; i < 40 && m_ph != 0; i++) tick();
    check("to_idle", phase, 0);
    flag_z1 = 0;
    tick();
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    tick();
    #3;
    reset = 1;

    // basic run with both flags low
    load = 1;
    tick();
    check("r20_init", {phase, step}, {3'd1, 4'd0});
    load = 0;
    repeat (14) tick();
    check("r20_loop0", {phase, step}, {3'd5, 4'd0});
    run_to_idle();

    // exchange path, loop exits at last step
    load = 1;
    tick();
    load = 0;
    for (int n = 2; n <= 32; n++) begin
      flag_s1 = (m_ph == 2);
      flag_z1 = (m_ph == 5 && m_st >= 5);
      tick();
      if (n == 13) check("r21_exch", {phase, step}, {3'd3, 4'd0});
      if (n == 28) check("r21_loop10", {phase, step}, {3'd5, 4'd10});
      if (n == 31) check("r21_done", {done, phase, iter}, 6'b1_000_00);
      if (n == 32) check("r21_pulse", done, 0);
    end
    flag_s1 = 0;
    flag_z1 = 0;

    // iteration overflow
    load = 1;
    tick();
    load = 0;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (n == 21) check("r22_it1", iter, 1);
      if (n == 33) check("r22_it3", iter, 3);
      if (n == 39) check("r22_err", {phase, err, iter}, 6'b111_1_11);
      if (n == 40) check("r22_idle", {phase, err, iter}, 6'b000_1_11);
    end
    load = 1;
    tick();
    check("r22_clr", {phase, err, iter}, 6'b001_0_00);
    load = 0;
    run_to_idle();

`ifdef SEQ_CTRL_SCAN_EN
    scan_en = 1; scan_phase = 3'd2; scan_step = 4'd3;
    flag_z1 = 1;
    tick();
    scan_en = 0;
    tick();
    check("r23_end", {phase, step}, {3'd6, 4'd0});
    flag_z1 = 0;
    scan_en = 1; scan_phase = 3'd1; scan_step = 4'd3;
    flag_s1 = 1;
    tick();
    scan_en = 0;
    tick();
    check("r23_abort", {phase, done}, {3'd0, 1'b0});
    flag_s1 = 0;
    scan_en = 1; scan_phase = 3'd0; scan_step = 4'd9;
    tick();
    scan_en = 0;
    tick();
    check("r23_illegal", {phase, step}, {3'd0, 4'd0});
`endif

    // async reset from LOOP/4
    load = 1;
    tick();
    load = 0;
`ifndef SEQ_CTRL_SCAN_EN
    scan_en = 1; scan_phase = 3'd7; scan_step = 4'd9;
`endif
    for (int i = 0; i < 30 && !(m_ph == 5 && m_st == 4); i++)
      tick();
    check("r24_loop4", {phase, step}, {3'd5, 4'd4});
    scan_en = 0;
    #2;
    reset = 0;
    #1;
    model_reset();
    compare_all();
    tick();
    #2;
    reset = 1;

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      load       = ($urandom % 4) == 0;
      flag_z1    = ($urandom % 3) == 0;
      flag_s1    = ($urandom % 4) == 0;
      scan_en    = ($urandom % 32) == 0;
      scan_phase = 3'($urandom);
      scan_step  = 4'($urandom);
      if (($urandom % 250) == 0) begin
        #2;
        reset = 0;
        #1;
        model_reset();
        compare_all();
        tick();
        #2;
        reset = 1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
